cart_bus_initiator: RTL and testbench
=====================================

Name: cart_bus_initiator

Overview:
- Console-side initiator for the cartridge PRG (CPU) and CHR (PPU) buses; it drives the strobes, addresses and write data that every mapper responds to.
- Accepts single-transaction requests from the CPU core and the PPU core, holds the read strobe until the mapper's registered data-enable returns, and captures the data.
- Reads the mapper never answers complete with an open-bus value after a timeout.
- The PRG and CHR channels are independent and may be active in the same cycle.

Parameters:
- TIMEOUT_CYCLES, 4, cycles spent in READ without a data-enable before the read completes with open-bus data (legal range 2..15).
- CHR_OPEN_BUS_EN, 1, 1: a timed-out CHR read returns the CHR latch; 0: it returns 8'h00.

Ports:
- cart_clk_in  input  1  sole clock, shared with the mapper.
- reset_n_in  input  1  asynchronous, active-low reset.
- cpu_req_in  input  1  one-cycle request pulse, accepted only when cpu_busy_out=0.
- cpu_we_in  input  1  1=write, 0=read; sampled with cpu_req_in.
- cpu_addr_in  input  16  CPU address; sampled with cpu_req_in.
- cpu_wdata_in  input  8  write data; sampled with cpu_req_in.
- cpu_busy_out  output  1  high from the cycle after acceptance through the ack cycle.
- cpu_ack_out  output  1  one-cycle completion pulse.
- cpu_rdata_out  output  8  read result; valid while cpu_ack_out=1 and held until the next ack.
- prg_timeout_out  output  1  one-cycle pulse, coincident with cpu_ack_out, on a timed-out read.
- ppu_req_in, ppu_we_in  input  1 each  as the CPU equivalents.
- ppu_addr_in  input  14  PPU address.
- ppu_wdata_in  input  8  PPU write data.
- ppu_busy_out, ppu_ack_out, chr_timeout_out  output  1 each  as the CPU equivalents.
- ppu_rdata_out  output  8  as cpu_rdata_out.
- prg_read_out, prg_write_out  output  1 each  PRG strobes to the mapper.
- prg_address_out  output  16  PRG address to the mapper.
- prg_data_out  output  8  PRG write data to the mapper.
- prg_data_en_in  input  1  mapper's registered PRG data-valid.
- prg_data_in  input  8  mapper's PRG data.
- chr_read_out, chr_write_out  output  1 each  CHR strobes.
- chr_address_out  output  14  CHR address.
- chr_data_out  output  8  CHR write data.
- chr_data_en_in  input  1  mapper's registered CHR data-valid.
- chr_data_in  input  8  mapper's CHR data.

Behaviour:
- Reset (asynchronous): every output and every internal register clears to 0, including the open-bus latches and the timeout counters. FSMs go to IDLE. A strobe that is high drops in the same instant. A transaction interrupted by reset never acks.
- All outputs are registered. Each channel is an identical FSM; PRG is described, CHR is the same with its own signals.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On req with busy=0: latch address and wdata, set busy, go to READ (we=0) or WRITE (we=1).
  - In the following cycle the address is driven and the selected strobe is high.
- A req that arrives while busy=1 is ignored entirely: no latching, no queueing.
- READ:
  - prg_read_out=1 and the address is held stable. A 4-bit counter increments each READ cycle.
  - If prg_data_en_in=1: capture prg_data_in into rdata and into the open-bus latch, go to DONE.
  - Else, if the counter reaches TIMEOUT_CYCLES-1 this cycle: rdata takes the open-bus latch, arm the timeout pulse, go to DONE.
  - If data-enable and the timeout coincide, the data wins and no timeout pulse is issued.
- WRITE:
  - prg_write_out=1 and prg_data_out=wdata for exactly one cycle.
  - The open-bus latch takes wdata. Go to DONE.
- DONE: ack=1 for one cycle (plus prg_timeout_out if armed). Strobes are 0. busy clears at the end of this cycle and the FSM returns to IDLE. A req in the DONE cycle is ignored.
- Latency, with the request accepted at edge T:
  - Read with a next-cycle data-enable: read strobe high T+1..T+2, ack at T+3.
  - Timeout: read strobe high T+1..T+TIMEOUT_CYCLES, ack at T+TIMEOUT_CYCLES+1.
  - Write: strobe at T+1, ack at T+2.
- Back-to-back throughput: one transaction per channel every 4 cycles (read) or every 3 cycles (write).
- prg_data_en_in and chr_data_en_in are ignored outside READ; a stray enable causes no capture.
- prg_address_out keeps its last value in IDLE; only the strobes qualify it.
- CHR open bus: with CHR_OPEN_BUS_EN=0, a timed-out CHR read returns 8'h00. The CHR latch is still updated on successful reads and writes.
- The counter clears on entry to READ and does not wrap; timeout is forced at TIMEOUT_CYCLES-1.

Test Plan:
1. Assert reset mid-bench with random inputs -> all outputs 0 asynchronously, before the next clock edge.
2. CPU read of 16'h8000; mapper model raises prg_data_en_in one cycle after the strobe with 8'hA9 -> prg_read_out high exactly 2 cycles, cpu_ack_out at T+3, cpu_rdata_out=8'hA9, prg_timeout_out=0.
3. CPU read of 16'h4020 with no data-enable, TIMEOUT_CYCLES=4 -> strobe high for 4 cycles, ack at T+5 with rdata=8'hA9 (latch), prg_timeout_out pulses with the ack. Repeat with the data-enable on the terminal cycle -> data returned, no timeout pulse.
4. CPU write of 16'h8000 with 8'h55 -> prg_write_out high 1 cycle with prg_data_out=8'h55, ack at T+2. A following unanswered read returns 8'h55.
5. CPU read and PPU read of 14'h0010 accepted on the same edge -> both ack at T+3 with independent data. A second cpu_req_in at T+1 is ignored: no extra strobe, no extra ack.
6. Assert reset at T+2 of a read -> prg_read_out drops immediately and no ack is issued. After release, a read of 16'hFFFC completes normally with ack at T+3.

Source files
------------

// File: rtl/cart_bus_initiator_if.sv
// Cartridge bus bundle: CPU/PPU request side plus PRG/CHR mapper side.
// req is taken only while busy=0; ack is a one-cycle completion pulse; busy drops after the ack cycle.
interface cart_bus_initiator_if;
  logic        cpu_req_in;
  logic        cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic        cpu_busy_out;
  logic        cpu_ack_out;
  logic [7:0]  cpu_rdata_out;
  logic        prg_timeout_out;

  logic        ppu_req_in;
  logic        ppu_we_in;
  logic [13:0] ppu_addr_in;
  logic [7:0]  ppu_wdata_in;
  logic        ppu_busy_out;
  logic        ppu_ack_out;
  logic [7:0]  ppu_rdata_out;
  logic        chr_timeout_out;

  logic        prg_read_out;
  logic        prg_write_out;
  logic [15:0] prg_address_out;
  logic [7:0]  prg_data_out;
  logic        prg_data_en_in;
  logic [7:0]  prg_data_in;

  logic        chr_read_out;
  logic        chr_write_out;
  logic [13:0] chr_address_out;
  logic [7:0]  chr_data_out;
  logic        chr_data_en_in;
  logic [7:0]  chr_data_in;

  modport master (
    input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    output cpu_busy_out, cpu_ack_out, cpu_rdata_out, prg_timeout_out,
    input  ppu_req_in, ppu_we_in, ppu_addr_in, ppu_wdata_in,
    output ppu_busy_out, ppu_ack_out, ppu_rdata_out, chr_timeout_out,
    output prg_read_out, prg_write_out, prg_address_out, prg_data_out,
    input  prg_data_en_in, prg_data_in,
    output chr_read_out, chr_write_out, chr_address_out, chr_data_out,
    input  chr_data_en_in, chr_data_in
  );

  modport slave (
    output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    input  cpu_busy_out, cpu_ack_out, cpu_rdata_out, prg_timeout_out,
    output ppu_req_in, ppu_we_in, ppu_addr_in, ppu_wdata_in,
    input  ppu_busy_out, ppu_ack_out, ppu_rdata_out, chr_timeout_out,
    input  prg_read_out, prg_write_out, prg_address_out, prg_data_out,
    output prg_data_en_in, prg_data_in,
    input  chr_read_out, chr_write_out, chr_address_out, chr_data_out,
    output chr_data_en_in, chr_data_in
  );
endinterface

// File: rtl/cart_bus_initiator.sv
// Console-side PRG/CHR bus initiator: two independent single-transaction channels
// that strobe the mapper, wait for its data-enable, and fall back to open bus on timeout.
module cart_bus_channel #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 4,
  parameter bit OPEN_BUS_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              busy,
  output logic              ack,
  output logic [7:0]        rdata,
  output logic              timeout,
  output logic              rd_strobe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_out,
  input  logic              data_en,
  input  logic [7:0]        data_in,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] open_bus;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      open_bus  <= 8'h00;
      busy      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= 8'h00;
      timeout   <= 1'b0;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      address   <= '0;
      data_out  <= 8'h00;
    end else begin
      ack     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            address <= req_addr;
            busy    <= 1'b1;
            cnt     <= 4'd0;
            if (we) begin
              data_out  <= req_wdata;
              wr_strobe <= 1'b1;
              state     <= WRITE;
            end else begin
              rd_strobe <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: begin
          // A data-enable on the terminal cycle still wins over the timeout.
          if (data_en) begin
            rdata     <= data_in;
            open_bus  <= data_in;
            rd_strobe <= 1'b0;
            ack       <= 1'b1;
            state     <= DONE;
          end else if (cnt == 4'(TIMEOUT_CYCLES - 1)) begin
            rdata     <= OPEN_BUS_EN ? open_bus : 8'h00;
            timeout   <= 1'b1;
            rd_strobe <= 1'b0;
            ack       <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          open_bus  <= data_out;
          wr_strobe <= 1'b0;
          ack       <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module cart_bus_initiator #(
  parameter int TIMEOUT_CYCLES  = 4,
  parameter bit CHR_OPEN_BUS_EN = 1'b1
) (
  input  logic                 cart_clk_in,
  input  logic                 reset_n_in,
  cart_bus_initiator_if.master bus,
  output logic [1:0]           prg_state,
  output logic [1:0]           chr_state
);

  cart_bus_channel #(
    .ADDR_W(16), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .OPEN_BUS_EN(1'b1)
  ) u_prg (
    .clk       (cart_clk_in),
    .rst_n     (reset_n_in),
    .req       (bus.cpu_req_in),
    .we        (bus.cpu_we_in),
    .req_addr  (bus.cpu_addr_in),
    .req_wdata (bus.cpu_wdata_in),
    .busy      (bus.cpu_busy_out),
    .ack       (bus.cpu_ack_out),
    .rdata     (bus.cpu_rdata_out),
    .timeout   (bus.prg_timeout_out),
    .rd_strobe (bus.prg_read_out),
    .wr_strobe (bus.prg_write_out),
    .address   (bus.prg_address_out),
    .data_out  (bus.prg_data_out),
    .data_en   (bus.prg_data_en_in),
    .data_in   (bus.prg_data_in),
    .state_dbg (prg_state)
  );

  cart_bus_channel #(
    .ADDR_W(14), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .OPEN_BUS_EN(CHR_OPEN_BUS_EN)
  ) u_chr (
    .clk       (cart_clk_in),
    .rst_n     (reset_n_in),
    .req       (bus.ppu_req_in),
    .we        (bus.ppu_we_in),
    .req_addr  (bus.ppu_addr_in),
    .req_wdata (bus.ppu_wdata_in),
    .busy      (bus.ppu_busy_out),
    .ack       (bus.ppu_ack_out),
    .rdata     (bus.ppu_rdata_out),
    .timeout   (bus.chr_timeout_out),
    .rd_strobe (bus.chr_read_out),
    .wr_strobe (bus.chr_write_out),
    .address   (bus.chr_address_out),
    .data_out  (bus.chr_data_out),
    .data_en   (bus.chr_data_en_in),
    .data_in   (bus.chr_data_in),
    .state_dbg (chr_state)
  );

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Directed and randomized bench for cart_bus_initiator against a cycle-count reference model.
module tb_cart_bus_initiator;
  localparam int TO     = 4;
  localparam bit CHR_OB = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cart_bus_initiator_if bus();
  logic [1:0] prg_state, chr_state;

  cart_bus_initiator #(.TIMEOUT_CYCLES(TO), .CHR_OPEN_BUS_EN(CHR_OB)) dut (
    .cart_clk_in (clk),
    .reset_n_in  (rst_n),
    .bus         (bus),
    .prg_state   (prg_state),
    .chr_state   (chr_state)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] prg_latch = 8'h00;
  logic [7:0] chr_latch = 8'h00;

  typedef struct {
    bit          en;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          d;   // cycle index (0 = first strobe cycle) of the mapper's data-enable; -1 = never
    logic [7:0]  rd;
  } op_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_req_in = 0; bus.cpu_we_in = 0; bus.cpu_addr_in = 0; bus.cpu_wdata_in = 0;
    bus.ppu_req_in = 0; bus.ppu_we_in = 0; bus.ppu_addr_in = 0; bus.ppu_wdata_in = 0;
    bus.prg_data_en_in = 0; bus.prg_data_in = 0;
    bus.chr_data_en_in = 0; bus.chr_data_in = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.prg_read_out, bus.prg_write_out, bus.chr_read_out, bus.chr_write_out,
                         bus.cpu_busy_out, bus.ppu_busy_out, bus.cpu_ack_out, bus.ppu_ack_out,
                         bus.prg_timeout_out, bus.chr_timeout_out}, 32'h0);
    chk({tag, "_prg_addr"}, bus.prg_address_out, 32'h0);
    chk({tag, "_chr_addr"}, bus.chr_address_out, 32'h0);
    chk({tag, "_data"}, {bus.prg_data_out, bus.chr_data_out, bus.cpu_rdata_out, bus.ppu_rdata_out}, 32'h0);
    chk({tag, "_state"}, {prg_state, chr_state}, 32'h0);
  endtask

  function automatic op_t mk(input bit en, input bit we, input logic [15:0] a,
                             input logic [7:0] wd, input int d, input logic [7:0] rd);
    op_t o;
    o.en = en; o.we = we; o.addr = a; o.wd = wd; o.d = d; o.rd = rd;
    return o;
  endfunction

  // Issues one request per enabled channel on the same edge and watches both to completion.
  task automatic run(input op_t c, input op_t p, input bit extra_req);
    bit c_resp, p_resp;
    int c_len, p_len;
    logic [7:0] c_exp, p_exp;
    int c_rd_n = 0, c_wr_n = 0, c_acks = 0, c_at = -1;
    int p_rd_n = 0, p_wr_n = 0, p_acks = 0, p_at = -1;
    c_resp = !c.we && c.d >= 0 && c.d < TO;
    p_resp = !p.we && p.d >= 0 && p.d < TO;
    c_len  = c.we ? 1 : (c_resp ? c.d + 1 : TO);
    p_len  = p.we ? 1 : (p_resp ? p.d + 1 : TO);
    c_exp  = c_resp ? c.rd : prg_latch;
    p_exp  = p_resp ? p.rd : (CHR_OB ? chr_latch : 8'h00);

    bus.cpu_req_in = c.en; bus.cpu_we_in = c.we; bus.cpu_addr_in = c.addr; bus.cpu_wdata_in = c.wd;
    bus.ppu_req_in = p.en; bus.ppu_we_in = p.we; bus.ppu_addr_in = p.addr[13:0]; bus.ppu_wdata_in = p.wd;
    tick();
    for (int i = 0; i < TO + 4; i++) begin
      bus.cpu_req_in = extra_req && (i == 0);
      bus.ppu_req_in = 0;
      if (extra_req && i == 0) begin
        bus.cpu_we_in = 1'b1;
        bus.cpu_addr_in = ~c.addr;
      end
      if (c.en) begin
        if (bus.prg_read_out) begin
          c_rd_n++;
          chk("prg_rd_addr", bus.prg_address_out, c.addr);
        end
        if (bus.prg_write_out) begin
          c_wr_n++;
          chk("prg_wr_addr", bus.prg_address_out, c.addr);
          chk("prg_wr_data", bus.prg_data_out, c.wd);
        end
        chk("cpu_busy", bus.cpu_busy_out, (i <= c_len));
        if (bus.cpu_ack_out) begin
          c_acks++;
          c_at = i;
          if (!c.we) chk("cpu_rdata", bus.cpu_rdata_out, c_exp);
          chk("prg_timeout", bus.prg_timeout_out, (!c.we && !c_resp));
        end else begin
          chk("prg_timeout_noack", bus.prg_timeout_out, 0);
        end
        bus.prg_data_en_in = (i == c.d);
        bus.prg_data_in = (i == c.d) ? c.rd : 8'($urandom);
      end
      if (p.en) begin
        if (bus.chr_read_out) begin
          p_rd_n++;
          chk("chr_rd_addr", bus.chr_address_out, p.addr[13:0]);
        end
        if (bus.chr_write_out) begin
          p_wr_n++;
          chk("chr_wr_addr", bus.chr_address_out, p.addr[13:0]);
          chk("chr_wr_data", bus.chr_data_out, p.wd);
        end
        chk("ppu_busy", bus.ppu_busy_out, (i <= p_len));
        if (bus.ppu_ack_out) begin
          p_acks++;
          p_at = i;
          if (!p.we) chk("ppu_rdata", bus.ppu_rdata_out, p_exp);
          chk("chr_timeout", bus.chr_timeout_out, (!p.we && !p_resp));
        end else begin
          chk("chr_timeout_noack", bus.chr_timeout_out, 0);
        end
        bus.chr_data_en_in = (i == p.d);
        bus.chr_data_in = (i == p.d) ? p.rd : 8'($urandom);
      end
      tick();
    end
    bus.prg_data_en_in = 0;
    bus.chr_data_en_in = 0;
    if (c.en) begin
      chk("prg_read_cycles", c_rd_n, c.we ? 0 : c_len);
      chk("prg_write_cycles", c_wr_n, c.we ? 1 : 0);
      chk("cpu_ack_count", c_acks, 1);
      chk("cpu_ack_cycle", c_at, c_len);
      if (c.we) prg_latch = c.wd;
      else if (c_resp) prg_latch = c.rd;
    end
    if (p.en) begin
      chk("chr_read_cycles", p_rd_n, p.we ? 0 : p_len);
      chk("chr_write_cycles", p_wr_n, p.we ? 1 : 0);
      chk("ppu_ack_count", p_acks, 1);
      chk("ppu_ack_cycle", p_at, p_len);
      if (p.we) chk_latch_upd(1'b1, p.wd);
      else if (p_resp) chk_latch_upd(1'b1, p.rd);
    end
  endtask

  task automatic chk_latch_upd(input bit upd, input logic [7:0] v);
    if (upd) chr_latch = v;
  endtask

  op_t none;

  initial begin
    none = mk(0, 0, 16'h0, 8'h0, -1, 8'h0);
    clear_inputs();
    tick();
    tick();
    chk_all_zero("reset_init");
    #2 rst_n = 1'b1;
    tick();

    // CPU read answered one cycle after the strobe.
    run(mk(1, 0, 16'h8000, 8'h00, 1, 8'hA9), none, 0);
    // Unanswered read returns the open-bus latch with a timeout pulse.
    run(mk(1, 0, 16'h4020, 8'h00, -1, 8'h00), none, 0);
    // Data-enable on the terminal cycle: data wins, no timeout.
    run(mk(1, 0, 16'h4020, 8'h00, TO - 1, 8'h3C), none, 0);
    // Write, then an unanswered read sees the written value on open bus.
    run(mk(1, 1, 16'h8000, 8'h55, -1, 8'h00), none, 0);
    run(mk(1, 0, 16'h6000, 8'h00, -1, 8'h00), none, 0);
    // Both channels on the same edge, plus an ignored second CPU request.
    run(mk(1, 0, 16'h8000, 8'h00, 1, 8'h12), mk(1, 0, 16'h0010, 8'h00, 1, 8'h34), 1);
    // CHR timeout returns the CHR latch.
    run(none, mk(1, 0, 16'h1FF0, 8'h00, -1, 8'h00), 0);

    // Reset mid-bench with random inputs driven.
    bus.cpu_req_in = 1; bus.cpu_we_in = 1'($urandom); bus.cpu_addr_in = 16'($urandom);
    bus.cpu_wdata_in = 8'($urandom);
    bus.ppu_req_in = 1; bus.ppu_we_in = 1'($urandom); bus.ppu_addr_in = 14'($urandom);
    bus.ppu_wdata_in = 8'($urandom);
    bus.prg_data_en_in = 1'($urandom); bus.prg_data_in = 8'($urandom);
    bus.chr_data_en_in = 1'($urandom); bus.chr_data_in = 8'($urandom);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_async");
    tick();
    chk_all_zero("reset_held");
    clear_inputs();
    #2 rst_n = 1'b1;
    prg_latch = 8'h00;
    chr_latch = 8'h00;
    tick();

    // Reset during a read: strobe drops at once and no ack follows.
    bus.cpu_req_in = 1; bus.cpu_we_in = 0; bus.cpu_addr_in = 16'h2000;
    tick();
    bus.cpu_req_in = 0;
    tick();
    chk("rd_before_reset", bus.prg_read_out, 1);
    #2 rst_n = 1'b0;
    #1 chk("rd_drop_async", bus.prg_read_out, 0);
    chk("busy_drop_async", bus.cpu_busy_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_ack_in_reset", bus.cpu_ack_out, 0);
    end
    #2 rst_n = 1'b1;
    prg_latch = 8'h00;
    chr_latch = 8'h00;
    tick();
    chk("no_ack_after_reset", bus.cpu_ack_out, 0);
    run(mk(1, 0, 16'hFFFC, 8'h00, 1, 8'hC3), none, 0);

    // Randomized mix on both channels.
    for (int n = 0; n < 40; n++) begin
      op_t c, p;
      c = mk(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
             int'($urandom_range(0, TO + 3)) - 1, 8'($urandom));
      p = mk(1'($urandom), 1'($urandom), 16'($urandom) & 16'h3FFF, 8'($urandom),
             int'($urandom_range(0, TO + 3)) - 1, 8'($urandom));
      if (!c.en && !p.en) c.en = 1'b1;
      run(c, p, 1'($urandom) & c.en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
